fft32_top: RTL and testbench

// - Fully parallel, pipelined 32-point radix-2 decimation-in-time FFT.
// - Accepts 32 real signed 8-bit samples every clock cycle.
// - Produces 32 complex bins every clock cycle after a fixed 4-cycle latency.
// - Top level of the FFT datapath: butterflies, twiddle multipliers and pipeline registers all live here.
// - Single clock domain; no separate MAC clock.

---
 rtl/fft32_top.sv | 180 ++++++++++++++++++
 tb/tb_fft32_top.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fft32_top.sv
// fft32_top: fully parallel 32-point radix-2 DIT FFT on real 8-bit samples.
// Four register ranks; one vector in and one spectrum out every clock.

module fft32_stage #(
    parameter int SPAN    = 1,
    parameter int TW_FRAC = 14
) (
    input  logic signed [15:0] a_re_i [32],
    input  logic signed [15:0] a_im_i [32],
    output logic signed [15:0] y_re_o [32],
    output logic signed [15:0] y_im_o [32]
);
    // round(16384*cos(2*pi*k/32)) and round(16384*sin(2*pi*k/32)), k = 0..15
    localparam int COS [16] = '{
        16384, 16069, 15137, 13623, 11585, 9102, 6270, 3196,
        0, -3196, -6270, -9102, -11585, -13623, -15137, -16069
    };
    localparam int SIN [16] = '{
        0, 3196, 6270, 9102, 11585, 13623, 15137, 16069,
        16384, 16069, 15137, 13623, 11585, 9102, 6270, 3196
    };
    localparam logic signed [31:0] RND = 32'sd1 <<< (TW_FRAC - 1);

    for (genvar g = 0; g < 32; g += 2 * SPAN) begin : g_grp
        for (genvar j = 0; j < SPAN; j++) begin : g_bf
            localparam int K  = j * (16 / SPAN);
            localparam int IA = g + j;
            localparam int IB = g + j + SPAN;

            logic signed [15:0] t_re;
            logic signed [15:0] t_im;

            if (K == 0) begin : g_w0
                assign t_re = a_re_i[IB];
                assign t_im = a_im_i[IB];
            end else if (K == 8) begin : g_w8
                assign t_re = a_im_i[IB];
                assign t_im = -a_re_i[IB];
            end else begin : g_mul
                logic signed [31:0] b_re;
                logic signed [31:0] b_im;
                logic signed [31:0] p_re;
                logic signed [31:0] p_im;
                assign b_re = 32'(a_re_i[IB]);
                assign b_im = 32'(a_im_i[IB]);
                assign p_re = b_re * 32'(COS[K]) + b_im * 32'(SIN[K]) + RND;
                assign p_im = b_im * 32'(COS[K]) - b_re * 32'(SIN[K]) + RND;
                assign t_re = 16'(p_re >>> TW_FRAC);
                assign t_im = 16'(p_im >>> TW_FRAC);
            end

            assign y_re_o[IA] = a_re_i[IA] + t_re;
            assign y_im_o[IA] = a_im_i[IA] + t_im;
            assign y_re_o[IB] = a_re_i[IA] - t_re;
            assign y_im_o[IB] = a_im_i[IA] - t_im;
        end
    end
endmodule

module fft32_top #(
    parameter int inNumOfBits  = 8,
    parameter int outNumOfBits = 32,
    parameter int TW_FRAC      = 14
) (
    input  logic                           CLK_10,
    input  logic                           RST,
    input  logic signed [inNumOfBits-1:0]  x0,  x1,  x2,  x3,
    input  logic signed [inNumOfBits-1:0]  x4,  x5,  x6,  x7,
    input  logic signed [inNumOfBits-1:0]  x8,  x9,  x10, x11,
    input  logic signed [inNumOfBits-1:0]  x12, x13, x14, x15,
    input  logic signed [inNumOfBits-1:0]  x16, x17, x18, x19,
    input  logic signed [inNumOfBits-1:0]  x20, x21, x22, x23,
    input  logic signed [inNumOfBits-1:0]  x24, x25, x26, x27,
    input  logic signed [inNumOfBits-1:0]  x28, x29, x30, x31,
    output logic [outNumOfBits-1:0]        X0,  X1,  X2,  X3,
    output logic [outNumOfBits-1:0]        X4,  X5,  X6,  X7,
    output logic [outNumOfBits-1:0]        X8,  X9,  X10, X11,
    output logic [outNumOfBits-1:0]        X12, X13, X14, X15,
    output logic [outNumOfBits-1:0]        X16, X17, X18, X19,
    output logic [outNumOfBits-1:0]        X20, X21, X22, X23,
    output logic [outNumOfBits-1:0]        X24, X25, X26, X27,
    output logic [outNumOfBits-1:0]        X28, X29, X30, X31
);
    function automatic int bitrev5(input int v);
        int r;
        r = 0;
        for (int b = 0; b < 5; b++) begin
            r = r | (((v >> b) & 1) << (4 - b));
        end
        return r;
    endfunction

    logic signed [inNumOfBits-1:0] xin [32];
    logic signed [15:0] r1_re_d [32], r1_re_q [32], r1_im [32];
    logic signed [15:0] s1_re [32], s1_im [32];
    logic signed [15:0] r2_re_d [32], r2_im_d [32];
    logic signed [15:0] r2_re_q [32], r2_im_q [32];
    logic signed [15:0] s3_re [32], s3_im [32];
    logic signed [15:0] r3_re_d [32], r3_im_d [32];
    logic signed [15:0] r3_re_q [32], r3_im_q [32];
    logic signed [15:0] r4_re_d [32], r4_im_d [32];
    logic signed [15:0] r4_re_q [32], r4_im_q [32];

    assign xin = '{x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,
                   x8,  x9,  x10, x11, x12, x13, x14, x15,
                   x16, x17, x18, x19, x20, x21, x22, x23,
                   x24, x25, x26, x27, x28, x29, x30, x31};

    // DIT wants bit-reversed input order; imaginary input is always zero
    for (genvar i = 0; i < 32; i++) begin : g_in
        assign r1_re_d[i] = 16'(xin[bitrev5(i)]);
        assign r1_im[i]   = '0;
    end

    fft32_stage #(.SPAN(1),  .TW_FRAC(TW_FRAC)) u_s1 (
        .a_re_i(r1_re_q), .a_im_i(r1_im), .y_re_o(s1_re),   .y_im_o(s1_im));
    fft32_stage #(.SPAN(2),  .TW_FRAC(TW_FRAC)) u_s2 (
        .a_re_i(s1_re),   .a_im_i(s1_im), .y_re_o(r2_re_d), .y_im_o(r2_im_d));
    fft32_stage #(.SPAN(4),  .TW_FRAC(TW_FRAC)) u_s3 (
        .a_re_i(r2_re_q), .a_im_i(r2_im_q), .y_re_o(s3_re), .y_im_o(s3_im));
    fft32_stage #(.SPAN(8),  .TW_FRAC(TW_FRAC)) u_s4 (
        .a_re_i(s3_re),   .a_im_i(s3_im), .y_re_o(r3_re_d), .y_im_o(r3_im_d));
    fft32_stage #(.SPAN(16), .TW_FRAC(TW_FRAC)) u_s5 (
        .a_re_i(r3_re_q), .a_im_i(r3_im_q), .y_re_o(r4_re_d), .y_im_o(r4_im_d));

    always_ff @(posedge CLK_10) begin
        for (int i = 0; i < 32; i++) begin
            if (RST) begin
                r1_re_q[i] <= '0;
                r2_re_q[i] <= '0;
                r2_im_q[i] <= '0;
                r3_re_q[i] <= '0;
                r3_im_q[i] <= '0;
                r4_re_q[i] <= '0;
                r4_im_q[i] <= '0;
            end else begin
                r1_re_q[i] <= r1_re_d[i];
                r2_re_q[i] <= r2_re_d[i];
                r2_im_q[i] <= r2_im_d[i];
                r3_re_q[i] <= r3_re_d[i];
                r3_im_q[i] <= r3_im_d[i];
                r4_re_q[i] <= r4_re_d[i];
                r4_im_q[i] <= r4_im_d[i];
            end
        end
    end

    assign X0  = outNumOfBits'({r4_re_q[0],  r4_im_q[0]});
    assign X1  = outNumOfBits'({r4_re_q[1],  r4_im_q[1]});
    assign X2  = outNumOfBits'({r4_re_q[2],  r4_im_q[2]});
    assign X3  = outNumOfBits'({r4_re_q[3],  r4_im_q[3]});
    assign X4  = outNumOfBits'({r4_re_q[4],  r4_im_q[4]});
    assign X5  = outNumOfBits'({r4_re_q[5],  r4_im_q[5]});
    assign X6  = outNumOfBits'({r4_re_q[6],  r4_im_q[6]});
    assign X7  = outNumOfBits'({r4_re_q[7],  r4_im_q[7]});
    assign X8  = outNumOfBits'({r4_re_q[8],  r4_im_q[8]});
    assign X9  = outNumOfBits'({r4_re_q[9],  r4_im_q[9]});
    assign X10 = outNumOfBits'({r4_re_q[10], r4_im_q[10]});
    assign X11 = outNumOfBits'({r4_re_q[11], r4_im_q[11]});
    assign X12 = outNumOfBits'({r4_re_q[12], r4_im_q[12]});
    assign X13 = outNumOfBits'({r4_re_q[13], r4_im_q[13]});
    assign X14 = outNumOfBits'({r4_re_q[14], r4_im_q[14]});
    assign X15 = outNumOfBits'({r4_re_q[15], r4_im_q[15]});
    assign X16 = outNumOfBits'({r4_re_q[16], r4_im_q[16]});
    assign X17 = outNumOfBits'({r4_re_q[17], r4_im_q[17]});
    assign X18 = outNumOfBits'({r4_re_q[18], r4_im_q[18]});
    assign X19 = outNumOfBits'({r4_re_q[19], r4_im_q[19]});
    assign X20 = outNumOfBits'({r4_re_q[20], r4_im_q[20]});
    assign X21 = outNumOfBits'({r4_re_q[21], r4_im_q[21]});
    assign X22 = outNumOfBits'({r4_re_q[22], r4_im_q[22]});
    assign X23 = outNumOfBits'({r4_re_q[23], r4_im_q[23]});
    assign X24 = outNumOfBits'({r4_re_q[24], r4_im_q[24]});
    assign X25 = outNumOfBits'({r4_re_q[25], r4_im_q[25]});
    assign X26 = outNumOfBits'({r4_re_q[26], r4_im_q[26]});
    assign X27 = outNumOfBits'({r4_re_q[27], r4_im_q[27]});
    assign X28 = outNumOfBits'({r4_re_q[28], r4_im_q[28]});
    assign X29 = outNumOfBits'({r4_re_q[29], r4_im_q[29]});
    assign X30 = outNumOfBits'({r4_re_q[30], r4_im_q[30]});
    assign X31 = outNumOfBits'({r4_re_q[31], r4_im_q[31]});
endmodule

// File: tb/tb_fft32_top.sv
// tb_fft32_top: random and directed vectors against an in-bench
// iterative DIT FFT model delayed through a four-deep expectation pipe.

module tb_fft32_top;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic signed [7:0] xi [32];
    logic [31:0]       xo [32];

    fft32_top dut (
        .CLK_10(clk), .RST(rst),
        .x0(xi[0]),   .x1(xi[1]),   .x2(xi[2]),   .x3(xi[3]),
        .x4(xi[4]),   .x5(xi[5]),   .x6(xi[6]),   .x7(xi[7]),
        .x8(xi[8]),   .x9(xi[9]),   .x10(xi[10]), .x11(xi[11]),
        .x12(xi[12]), .x13(xi[13]), .x14(xi[14]), .x15(xi[15]),
        .x16(xi[16]), .x17(xi[17]), .x18(xi[18]), .x19(xi[19]),
        .x20(xi[20]), .x21(xi[21]), .x22(xi[22]), .x23(xi[23]),
        .x24(xi[24]), .x25(xi[25]), .x26(xi[26]), .x27(xi[27]),
        .x28(xi[28]), .x29(xi[29]), .x30(xi[30]), .x31(xi[31]),
        .X0(xo[0]),   .X1(xo[1]),   .X2(xo[2]),   .X3(xo[3]),
        .X4(xo[4]),   .X5(xo[5]),   .X6(xo[6]),   .X7(xo[7]),
        .X8(xo[8]),   .X9(xo[9]),   .X10(xo[10]), .X11(xo[11]),
        .X12(xo[12]), .X13(xo[13]), .X14(xo[14]), .X15(xo[15]),
        .X16(xo[16]), .X17(xo[17]), .X18(xo[18]), .X19(xo[19]),
        .X20(xo[20]), .X21(xo[21]), .X22(xo[22]), .X23(xo[23]),
        .X24(xo[24]), .X25(xo[25]), .X26(xo[26]), .X27(xo[27]),
        .X28(xo[28]), .X29(xo[29]), .X30(xo[30]), .X31(xo[31])
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int cosk [16];
    int sink [16];
    logic [31:0] pipe [4][32];
    logic [31:0] mo [32];
    logic signed [7:0] vimp [32], vdc [32], vneg [32], valt [32], vz [32];

    function automatic int brev(input int v);
        int r;
        r = 0;
        for (int b = 0; b < 5; b++) r = r | (((v >> b) & 1) << (4 - b));
        return r;
    endfunction

    // Textbook in-place radix-2 DIT FFT with the fixed-point twiddle rule
    function automatic void model(input logic signed [7:0] v [32],
                                  output logic [31:0] o [32]);
        int re [32];
        int im [32];
        int h, k, a, b, tr, ti, ar, ai;
        for (int i = 0; i < 32; i++) begin
            re[i] = int'(v[brev(i)]);
            im[i] = 0;
        end
        for (int s = 1; s <= 5; s++) begin
            h = 1 << (s - 1);
            for (int g = 0; g < 32; g += 2 * h) begin
                for (int j = 0; j < h; j++) begin
                    k = j * (16 / h);
                    a = g + j;
                    b = a + h;
                    if (k == 0) begin
                        tr = re[b]; ti = im[b];
                    end else if (k == 8) begin
                        tr = im[b]; ti = -re[b];
                    end else begin
                        tr = (re[b] * cosk[k] + im[b] * sink[k] + 8192) >>> 14;
                        ti = (im[b] * cosk[k] - re[b] * sink[k] + 8192) >>> 14;
                    end
                    ar = re[a]; ai = im[a];
                    re[a] = ar + tr; im[a] = ai + ti;
                    re[b] = ar - tr; im[b] = ai - ti;
                end
            end
        end
        for (int i = 0; i < 32; i++) o[i] = {re[i][15:0], im[i][15:0]};
    endfunction

    task automatic lit(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // One clock: pipe[0] takes what the DUT samples on this edge
    task automatic step();
        @(posedge clk);
        for (int s = 3; s > 0; s--) pipe[s] = pipe[s - 1];
        if (rst) begin
            for (int s = 0; s < 4; s++)
                for (int i = 0; i < 32; i++) pipe[s][i] = '0;
        end else begin
            model(xi, mo);
            pipe[0] = mo;
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 32; k++) begin
                total++;
                if (xo[k] !== pipe[3][k]) begin
                    bad++;
                    $display("FAIL bin%0d t=%0t got=%h exp=%h",
                             k, $time, xo[k], pipe[3][k]);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 16; k++) begin
            cosk[k] = $rtoi($floor(16384.0 * $cos(2.0 * 3.14159265358979 * k / 32.0) + 0.5));
            sink[k] = $rtoi($floor(16384.0 * $sin(2.0 * 3.14159265358979 * k / 32.0) + 0.5));
        end
        for (int i = 0; i < 32; i++) begin
            vimp[i] = (i == 0) ? 8'sd1 : 8'sd0;
            vdc[i]  = 8'sd1;
            vneg[i] = -8'sd128;
            valt[i] = (i % 2 == 0) ? 8'sd10 : -8'sd10;
            vz[i]   = 8'sd0;
        end

        model(vimp, mo);
        for (int k = 0; k < 32; k++) lit("model_imp", mo[k], 32'h00010000);
        model(vdc, mo);
        lit("model_dc0", mo[0], 32'h00200000);
        for (int k = 1; k < 32; k++) lit("model_dc", mo[k], 32'h0);
        model(vneg, mo);
        lit("model_neg0", mo[0], 32'hF0000000);
        lit("model_neg7", mo[7], 32'h0);
        model(valt, mo);
        lit("model_alt16", mo[16], 32'h01400000);
        lit("model_alt0", mo[0], 32'h0);
        lit("model_alt3", mo[3], 32'h0);

        @(negedge clk);
        for (int i = 0; i < 32; i++) xi[i] = 8'($urandom);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        xi = vz;
        lit("rst_X0", xo[0], 32'h0);
        lit("rst_X31", xo[31], 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            lit("post_rst_X0", xo[0], 32'h0);
        end

        xi = vimp; step();
        xi = vdc;  step();
        xi = valt; step();
        xi = vneg; step();
        lit("strm_imp_X0", xo[0], 32'h00010000);
        lit("strm_imp_X5", xo[5], 32'h00010000);
        xi = vz; step();
        lit("strm_dc_X0", xo[0], 32'h00200000);
        lit("strm_dc_X1", xo[1], 32'h0);
        step();
        lit("strm_alt_X16", xo[16], 32'h01400000);
        lit("strm_alt_X0", xo[0], 32'h0);
        step();
        lit("strm_neg_X0", xo[0], 32'hF0000000);

        xi = vimp; step();
        xi = vdc;  step();
        rst = 1'b1; xi = valt; step();
        rst = 1'b0; xi = vz;
        lit("mid_rst_X0", xo[0], 32'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            lit("mid_rst_X0", xo[0], 32'h0);
            lit("mid_rst_X16", xo[16], 32'h0);
        end

        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 32; i++) xi[i] = 8'($urandom);
            if ($urandom_range(0, 9) == 0) xi[$urandom_range(0, 31)] = -8'sd128;
            rst = ($urandom_range(0, 39) == 0);
            step();
        end
        rst = 1'b0;
        xi = vneg;
        step();
        xi = vz;
        for (int c = 0; c < 4; c++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
